lif_neuron_core: RTL and testbench

- Leaky integrate-and-fire neuron that produces the postsynaptic spike consumed by the STDP weight-update block as postsynapSR0.
- Once per timestep it walks the 16 presynaptic spike lines and reads each 4-bit synaptic weight from the STDP block's weight array through an index/data port (the same select/mux style that block uses).
- It accumulates weights of spiking inputs, applies leak, compares against threshold, and fires.
- Single clock domain, time-multiplexed: one synapse per cycle.

---
 rtl/lif_neuron_core.sv | 116 +++++++++++
 tb/tb_lif_neuron_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: walks 16 presynaptic lines one per cycle,
// integrates spiking weights, leaks, and fires against a fixed threshold.
//
// state | meaning
// IDLE  | waiting for step_start
// ACCUM | one synapse per cycle, idx 0..15
// LEAK  | potential -= potential >> LEAK_SHIFT
// FIRE  | threshold compare, spike/step_done pulse
// REFR  | refractory step, counter decrements
module lif_neuron_core #(
  parameter int N_SYN         = 16,
  parameter int W_W           = 4,
  parameter int POT_W         = 10,
  parameter int THRESH        = 200,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRACT_STEPS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_start,
  input  logic [N_SYN-1:0] presyn_spikes,
  output logic [3:0]       weight_addr,
  input  logic [W_W-1:0]   weight_data,
  output logic             postsyn_spike,
  output logic             step_done,
  output logic             busy,
  output logic [POT_W-1:0] membrane_pot,
  output logic             refract_active
);

  localparam int REF_W = (REFRACT_STEPS < 1) ? 1 : $clog2(REFRACT_STEPS + 1);
  localparam logic [REF_W-1:0] REF_INIT = REF_W'(REFRACT_STEPS);
  localparam logic [POT_W-1:0] THRESH_V = POT_W'(THRESH);

  typedef enum logic [2:0] {IDLE, ACCUM, LEAK, FIRE, REFR} stateT;

  stateT            state;
  logic [3:0]       idx;
  logic [N_SYN-1:0] spikeLatch;
  logic [POT_W-1:0] membranePot;
  logic [REF_W-1:0] refractCnt;
  logic             postSpike;
  logic             stepDone;

  logic [POT_W:0]   sumWide;
  logic [POT_W-1:0] satSum;
  logic [POT_W-1:0] leakVal;

  always_comb begin
    sumWide = {1'b0, membranePot} + (POT_W+1)'(weight_data);
    satSum  = sumWide[POT_W] ? {POT_W{1'b1}} : sumWide[POT_W-1:0];
    leakVal = membranePot - (membranePot >> LEAK_SHIFT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      spikeLatch  <= '0;
      membranePot <= '0;
      refractCnt  <= '0;
      postSpike   <= 1'b0;
      stepDone    <= 1'b0;
    end else begin
      postSpike <= 1'b0;
      stepDone  <= 1'b0;
      case (state)
        IDLE: begin
          // a request landing on the step_done cycle belongs to the finishing step
          if (step_start && !stepDone) begin
            if (refractCnt == '0) begin
              spikeLatch <= presyn_spikes;
              idx        <= '0;
              state      <= ACCUM;
            end else begin
              state <= REFR;
            end
          end
        end
        ACCUM: begin
          if (spikeLatch[idx]) membranePot <= satSum;
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= LEAK;
        end
        LEAK: begin
          membranePot <= leakVal;
          state       <= FIRE;
        end
        FIRE: begin
          if (membranePot >= THRESH_V) begin
            postSpike   <= 1'b1;
            membranePot <= '0;
            refractCnt  <= REF_INIT;
          end
          stepDone <= 1'b1;
          state    <= IDLE;
        end
        REFR: begin
          refractCnt <= refractCnt - REF_W'(1);
          stepDone   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // idx wraps back to 0 after the last synapse, so the address rests at 0
  assign weight_addr    = idx;
  assign postsyn_spike  = postSpike;
  assign step_done      = stepDone;
  assign busy           = (state != IDLE);
  assign membrane_pot   = membranePot;
  assign refract_active = (refractCnt != '0);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Bench for lif_neuron_core: two instances (THRESH 200 and 1023) share stimulus;
// a per-step reference model fills scoreboards that a negedge monitor drains.
`timescale 1ns/1ps
module tb_lif_neuron_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_start;
  logic [15:0] presyn;
  logic [3:0]  wAddr [2];
  logic [3:0]  wData [2];
  logic        spike [2];
  logic        done [2];
  logic        busyS [2];
  logic        refrS [2];
  logic [9:0]  pot [2];
  logic [3:0]  weights [16];

  always #5 clock = ~clock;

  assign wData[0] = weights[wAddr[0]];
  assign wData[1] = weights[wAddr[1]];

  lif_neuron_core u0 (
    .clock(clock), .reset(reset), .step_start(step_start), .presyn_spikes(presyn),
    .weight_addr(wAddr[0]), .weight_data(wData[0]), .postsyn_spike(spike[0]),
    .step_done(done[0]), .busy(busyS[0]), .membrane_pot(pot[0]), .refract_active(refrS[0])
  );

  lif_neuron_core #(.THRESH(1023)) u1 (
    .clock(clock), .reset(reset), .step_start(step_start), .presyn_spikes(presyn),
    .weight_addr(wAddr[1]), .weight_data(wData[1]), .postsyn_spike(spike[1]),
    .step_done(done[1]), .busy(busyS[1]), .membrane_pot(pot[1]), .refract_active(refrS[1])
  );

  typedef struct {
    int  pot;
    bit  spk;
    bit  refr;
    int  cyc;
  } expT;

  expT q0[$];
  expT q1[$];
  int  mPot [2];
  int  mRefr [2];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int thr(input int d);
    return (d == 0) ? 200 : 1023;
  endfunction

  // One timestep of the neuron at the arithmetic level.
  task automatic modelStep(input logic [15:0] sp, input int issueCyc);
    for (int d = 0; d < 2; d++) begin
      expT e;
      if (mRefr[d] > 0) begin
        mRefr[d] = mRefr[d] - 1;
        e.spk = 1'b0;
        e.cyc = issueCyc + 2;
      end else begin
        int s;
        s = mPot[d];
        for (int i = 0; i < 16; i++) if (sp[i]) s = s + int'(weights[i]);
        if (s > 1023) s = 1023;
        s = s - s / 8;
        e.spk = 1'b0;
        if (s >= thr(d)) begin
          e.spk = 1'b1;
          s = 0;
          mRefr[d] = 2;
        end
        mPot[d] = s;
        e.cyc = issueCyc + 19;
      end
      e.pot  = mPot[d];
      e.refr = (mRefr[d] != 0);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          expT e;
          bit  have;
          have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (!have) begin
            check($sformatf("unexpected_done%0d", d), 1, 0);
          end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            check($sformatf("pot%0d", d), int'(pot[d]), e.pot);
            check($sformatf("spike%0d", d), int'(spike[d]), int'(e.spk));
            check($sformatf("refract%0d", d), int'(refrS[d]), int'(e.refr));
            check($sformatf("latency%0d", d), cyc, e.cyc);
            check($sformatf("addr_idle%0d", d), int'(wAddr[d]), 0);
          end
        end else if (spike[d]) begin
          check($sformatf("spike_no_done%0d", d), 1, 0);
        end
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while ((busyS[0] || busyS[1] || done[0] || done[1]) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) check("idle_timeout", 1, 0);
  endtask

  task automatic issueStep(input logic [15:0] sp);
    waitIdle();
    presyn     = sp;
    step_start = 1'b1;
    modelStep(sp, cyc);
    @(negedge clock);
    step_start = 1'b0;
    presyn     = 16'($urandom);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("busy_after_start%0d", d), int'(busyS[d]), 1);
      check($sformatf("addr_first%0d", d), int'(wAddr[d]), 0);
    end
  endtask

  task automatic checkCleared();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_pot%0d", d), int'(pot[d]), 0);
      check($sformatf("rst_spike%0d", d), int'(spike[d]), 0);
      check($sformatf("rst_done%0d", d), int'(done[d]), 0);
      check($sformatf("rst_busy%0d", d), int'(busyS[d]), 0);
      check($sformatf("rst_addr%0d", d), int'(wAddr[d]), 0);
      check($sformatf("rst_refr%0d", d), int'(refrS[d]), 0);
    end
  endtask

  task automatic doReset();
    reset      = 1'b1;
    step_start = 1'b0;
    q0.delete();
    q1.delete();
    mPot  = '{0, 0};
    mRefr = '{0, 0};
    #1;
    checkCleared();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic setWeights(input int w);
    for (int i = 0; i < 16; i++) weights[i] = 4'(w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    step_start = 1'b0;
    presyn     = '0;
    setWeights(0);
    repeat (3) @(negedge clock);
    doReset();

    // single weight 5 on line 0, leak of 5 is 0
    weights[0] = 4'd5;
    issueStep(16'h0001);
    waitIdle();
    check("single_pot", int'(pot[0]), 5);

    // full drive fires dut0, then two refractory steps, then normal
    setWeights(15);
    issueStep(16'hFFFF);
    waitIdle();
    check("fire_refr_active", int'(refrS[0]), 1);
    issueStep(16'($urandom));
    issueStep(16'($urandom));
    issueStep(16'h00F0);

    // 100 integrated, then leaks to 88, 77, 68, 60
    doReset();
    setWeights(0);
    for (int i = 0; i < 10; i++) weights[i] = 4'd10;
    issueStep(16'h03FF);
    waitIdle();
    check("leak_88", int'(pot[0]), 88);
    issueStep(16'h0000);
    issueStep(16'h0000);
    issueStep(16'h0000);
    waitIdle();
    check("leak_60", int'(pot[0]), 60);

    // stray step_start mid-accumulation is dropped
    setWeights(3);
    issueStep(16'h00FF);
    repeat (4) @(negedge clock);
    step_start = 1'b1;
    @(negedge clock);
    step_start = 1'b0;

    // reset mid-step abandons everything
    waitIdle();
    issueStep(16'hFFFF);
    repeat (6) @(negedge clock);
    doReset();
    issueStep(16'h0003);

    // step_start on the step_done cycle is dropped
    waitIdle();
    issueStep(16'h0101);
    for (int n = 0; n < 30 && !done[0]; n++) @(negedge clock);
    step_start = 1'b1;
    @(negedge clock);
    step_start = 1'b0;
    check("done_cycle_start0", int'(busyS[0]), 0);
    check("done_cycle_start1", int'(busyS[1]), 0);

    // saturation on the THRESH=1023 instance: settles at 896, never fires
    doReset();
    setWeights(15);
    for (int i = 0; i < 8; i++) issueStep(16'hFFFF);
    waitIdle();
    check("sat_bound", int'(pot[1]), 896);

    // randomized steps
    for (int i = 0; i < 40; i++) begin
      waitIdle();
      for (int k = 0; k < 16; k++) weights[k] = 4'($urandom_range(0, 15));
      issueStep(16'($urandom) | ((i % 3 == 0) ? 16'hFFFF : 16'h0000));
    end

    waitIdle();
    repeat (2) @(negedge clock);
    check("sb_empty0", q0.size(), 0);
    check("sb_empty1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
